// File: rtl/fifo_load_to_write_if.sv
// Load/Ready producer stream and FIFO write port of the load-to-write adapter.
// The DUT takes the slave view; the environment (producer + FIFO) takes master.
interface fifo_load_to_write_if #(
    parameter int DataWidth      = 8,
    parameter int DataCountWidth = 3
);
    logic                    Load;
    logic [DataWidth-1:0]    LoadData;
    logic                    Ready;
    logic                    Full;
    logic                    Write;
    logic [DataWidth-1:0]    WriteData;
    logic [DataCountWidth-1:0] DataCountIn;
    logic [DataCountWidth:0] DataCountOut;
    logic [1:0]              Held;
    logic                    Idle;

    modport master (
        output Load, LoadData, Full, DataCountIn,
        input  Ready, Write, WriteData, DataCountOut, Held, Idle
    );

    modport slave (
        input  Load, LoadData, Full, DataCountIn,
        output Ready, Write, WriteData, DataCountOut, Held, Idle
    );
endinterface

// File: rtl/fifo_load_to_write.sv
// Converts a Load/Ready stream into FIFO write strobes through a 2-entry
// holding buffer; Ready is a plain register so upstream timing is cut.
module fifo_load_to_write #(
    parameter int DataWidth      = 8,
    parameter int DataCountWidth = 3
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    fifo_load_to_write_if.slave  bus
);
    localparam int CntW = DataCountWidth + 1;

    typedef enum logic [1:0] {
        S_HELD0 = 2'd0,
        S_HELD1 = 2'd1,
        S_HELD2 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_ready;
    logic [DataWidth-1:0] r_h0;
    logic [DataWidth-1:0] r_h1;
    logic [DataWidth-1:0] w_h0_next;
    logic [DataWidth-1:0] w_h1_next;
    logic                 w_accept;
    logic                 w_write;
    logic                 w_nonempty;

    assign w_nonempty = (r_state != S_HELD0);
    assign w_accept   = bus.Load & r_ready;
    assign w_write    = ~bus.Full & (w_nonempty | w_accept);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state <= S_HELD0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != S_HELD2);
        end
    end

    // Buffer contents are don't-care while empty, so they carry no reset.
    always_ff @(posedge Clk) begin
        r_h0 <= w_h0_next;
        r_h1 <= w_h1_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_h0_next    = r_h0;
        w_h1_next    = r_h1;
        case (r_state)
            S_HELD0: begin
                if (w_accept && !w_write) begin
                    w_h0_next    = bus.LoadData;
                    w_state_next = S_HELD1;
                end
            end
            S_HELD1: begin
                if (w_accept && w_write) begin
                    w_h0_next = bus.LoadData;
                end else if (w_write) begin
                    w_state_next = S_HELD0;
                end else if (w_accept) begin
                    w_h1_next    = bus.LoadData;
                    w_state_next = S_HELD2;
                end
            end
            S_HELD2: begin
                // Ready is low here, so only the drain case exists.
                if (w_write) begin
                    w_h0_next    = r_h1;
                    w_state_next = S_HELD1;
                end
            end
            default: w_state_next = S_HELD0;
        endcase
    end

    assign bus.Ready        = r_ready;
    assign bus.Write        = w_write;
    assign bus.WriteData    = w_nonempty ? r_h0 : bus.LoadData;
    assign bus.Held         = r_state;
    assign bus.Idle         = ~w_nonempty;
    assign bus.DataCountOut = {1'b0, bus.DataCountIn} + CntW'(r_state);
endmodule
